mealy_seq_detector: RTL
=======================

Name: mealy_seq_detector

Overview:
Parametrised, runtime-programmable serial bit-pattern detector with a registered Mealy-style match output. It generalises the fixed "000" detector to any pattern of PAT_LEN bits and adds selectable overlapping or non-overlapping matching, an input-valid qualifier, a saturating match counter and an exposed state. It sits behind a serial bit source (UART/line decoder) and feeds match events to control logic.

Parameters:
PAT_LEN, 3, pattern length in bits (2..32).
DEFAULT_PAT, 3'b000, pattern loaded at reset. Bit PAT_LEN-1 is the first bit received.
CNT_W, 8, width of the match counter.

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  inp is sampled on this edge only when 1
inp  in  1  serial data bit
overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled on every valid bit
cfg_load  in  1  single-cycle pulse; loads cfg_pattern
cfg_pattern  in  PAT_LEN  new pattern; bit PAT_LEN-1 is the oldest/first bit
cnt_clr  in  1  synchronous clear of match_count
out  out  1  registered match pulse
match_count  out  CNT_W  saturating count of matches
det_state  out  2  current FSM state, encoded per the package

Behaviour:
- Reset (async, active-high): pattern=DEFAULT_PAT, history=0, fill=0, state=FILL, out=0, match_count=0.
- History: PAT_LEN-bit shift register. On each valid bit: hist <= {hist[PAT_LEN-2:0], inp}. fill counter, width $clog2(PAT_LEN+1), saturates at PAT_LEN.
- FSM states: FILL (fill<PAT_LEN), ARMED (fill==PAT_LEN), LOAD (one cycle after cfg_load). Encoding 2'b11 is illegal and recovers to FILL with out=0.
- Match condition, evaluated combinationally on a valid edge: (fill+1 >= PAT_LEN) and the new history equals the pattern.
- out: registered on the same edge that consumes the completing bit. It is high for exactly one cycle per match and 0 on any edge without a valid bit. Latency is one clock from the completing bit's sampling edge.
- overlap=1: fill stays saturated after a match, so a trailing prefix can start the next match.
- overlap=0: a match sets fill to 0 and state to FILL. The next match needs PAT_LEN fresh bits.
- cfg_load: pattern <= cfg_pattern, fill <= 0, out <= 0, state <= LOAD. The next cycle goes to FILL. cfg_load with in_valid in the same cycle: load wins and the bit is discarded. A valid bit during LOAD is accepted normally.
- match_count: increments on each match and saturates at all-ones; it never wraps. When cnt_clr coincides with a match, the clear wins (count=0) and out still pulses.
- in_valid=0: all state holds and out=0.
- rst asserted mid-stream: immediate return to reset values, including a pattern reloaded to DEFAULT_PAT.

Optional Feature:
SEQ_DET_MASK_EN
- Defined: adds input cfg_mask[PAT_LEN], loaded together with cfg_pattern; reset value is all-ones. Bits with mask=0 are don't-care in the comparison ((hist ^ pattern) & mask == 0). An all-zero mask matches on every valid bit once fill is satisfied.
- Undefined: the port is absent and the comparison is exact equality.

Decomposition:
- Package seq_det_pkg holds:
  - FILL/ARMED/LOAD state encodings (localparam, 2 bits) and the 2'b11 illegal value.
  - Function for the fill-counter width.
- Sub-module seq_det_sat_cnt: CNT_W saturating counter with inc and clr inputs, where clr has priority.

Test Plan:
- Reset, PAT_LEN=3, pattern 000, overlap=1, valid bits 0,0,0,0,0,0 -> out pulses after bits 3, 4, 5 and 6; match_count=4.
- Same stream with overlap=0 -> out pulses after bits 3 and 6 only; match_count=2; det_state returns to FILL after each match.
- Bits 0,0,0,1,1,1,1,0,1,1,1,0,1,0,1,0 with pattern 000 -> single pulse after bit 3; count=1. Then cfg_load 3'b101 -> the 1,0,1 inside the tail produces pulses, each checked against the golden model.
- cfg_load with in_valid in the same cycle, followed by 2 bits matching the pattern prefix -> no match until PAT_LEN post-load bits; det_state goes LOAD then FILL.
- CNT_W=2, five matches -> match_count stays at 3. cnt_clr coinciding with a match -> count=0 and out=1 in that cycle.
- rst pulsed mid-pattern after two 0s, then a single 0 -> no match; pattern equals DEFAULT_PAT. With SEQ_DET_MASK_EN, mask 3'b101 and pattern 000 -> stream 0,1,0 matches.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding and fill-counter sizing.
package seq_det_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'b00,
    ARMED   = 2'b01,
    LOAD    = 2'b10,
    ILLEGAL = 2'b11
  } det_state_t;

  // Bits needed to count 0..pat_len inclusive.
  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; a clear takes priority over an increment in the same cycle.
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Runtime-programmable serial pattern detector with registered match pulse and saturating count.
// Define SEQ_DET_MASK_EN to add a per-bit don't-care mask (cfg_mask) to the comparison.
module mealy_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned           PAT_LEN     = 3,
  parameter logic [PAT_LEN-1:0]    DEFAULT_PAT = '0,
  parameter int unsigned           CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               inp,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0] cfg_mask,
`endif
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         det_state
);

  localparam int FW = fill_width(int'(PAT_LEN));
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0] NEAR = FW'(PAT_LEN - 1);

  det_state_t         state, state_n;
  logic [PAT_LEN-1:0] pattern, pattern_n;
  logic [PAT_LEN-1:0] hist, hist_n, hist_shift;
  logic [FW-1:0]      fill, fill_n;
  logic [PAT_LEN-1:0] eff_mask;
  logic               hit, match, out_n;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_LEN-1:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '1;
    end else if (cfg_load) begin
      mask <= cfg_mask;
    end
  end

  assign eff_mask = mask;
`else
  assign eff_mask = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      pattern <= DEFAULT_PAT;
      hist    <= '0;
      fill    <= '0;
      out     <= 1'b0;
    end else begin
      state   <= state_n;
      pattern <= pattern_n;
      hist    <= hist_n;
      fill    <= fill_n;
      out     <= out_n;
    end
  end

  // A completing bit only needs PAT_LEN-1 bits already in history.
  always_comb begin
    hist_shift = {hist[PAT_LEN-2:0], inp};
    hit        = ((hist_shift ^ pattern) & eff_mask) == '0;
    match      = in_valid && !cfg_load && (state != ILLEGAL) && (fill >= NEAR) && hit;
    out_n      = match;
  end

  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    hist_n    = hist;
    fill_n    = fill;
    if (cfg_load) begin
      pattern_n = cfg_pattern;
      fill_n    = '0;
      state_n   = LOAD;
    end else if (state == ILLEGAL) begin
      state_n = FILL;
    end else if (in_valid) begin
      hist_n = hist_shift;
      if (match && !overlap) begin
        fill_n  = '0;
        state_n = FILL;
      end else begin
        fill_n  = (fill == FULL) ? fill : fill + FW'(1);
        state_n = (fill_n == FULL) ? ARMED : FILL;
      end
    end else if (state == LOAD) begin
      state_n = FILL;
    end
  end

  assign det_state = state;

  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_count)
  );

endmodule
